// File: rtl/axi_rd.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd
// Description : Arbitrated AXI read engine serving I-cache line fills and
//               D-cache line fills / uncached single reads.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd #(
    parameter int BYTES_PER_LINE = 16,
    parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
    parameter int LINE_WIDTH     = WORDS_PER_LINE * 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_rd_req,
    input  logic [31:0]           i_rd_addr,
    output logic                  i_rd_rdy,
    output logic                  i_ret_valid,
    output logic [LINE_WIDTH-1:0] i_ret_data,

    input  logic                  d_rd_req,
    input  logic                  d_rd_burst,
    input  logic [1:0]            d_rd_size,
    input  logic [31:0]           d_rd_addr,
    output logic                  d_rd_rdy,
    output logic                  d_ret_valid,
    output logic [LINE_WIDTH-1:0] d_ret_data,

    input  logic                  wr_idle,
    output logic                  read_unfinish,

    output logic [3:0]            arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int                 OFFSET_BITS    = $clog2(BYTES_PER_LINE);
    localparam int                 PTR_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [31:0]        LINE_MASK      = ~((32'd1 << OFFSET_BITS) - 32'd1);
    localparam logic [7:0]         BURST_LEN      = 8'(WORDS_PER_LINE - 1);
    localparam logic [PTR_W-1:0]   LAST_BURST_PTR = PTR_W'(WORDS_PER_LINE - 1);
    localparam logic [1:0]         BURST_INCR     = 2'b01;
    localparam logic [1:0]         BURST_FIXED    = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               req_d_q, req_d_d;      // 1 = D requester, 0 = I requester
    logic [31:0]        addr_q, addr_d;
    logic               burst_q, burst_d;
    logic [1:0]         size_q, size_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        line_q [WORDS_PER_LINE];
    logic               buf_we;
    logic [PTR_W-1:0]   last_ptr;
    logic [LINE_WIDTH-1:0] line_data;
    logic               unused_r_fields;

    assign unused_r_fields = ^{rid, rresp};
    assign last_ptr        = burst_q ? LAST_BURST_PTR : '0;

    // AR fields come straight from the latched request, so they stay stable
    // for as long as the slave stalls arready.
    assign arid    = {3'b000, req_d_q};
    assign araddr  = burst_q ? (addr_q & LINE_MASK) : addr_q;
    assign arlen   = burst_q ? BURST_LEN : 8'd0;
    assign arsize  = burst_q ? 3'd2 : {1'b0, size_q};
    assign arburst = burst_q ? BURST_INCR : BURST_FIXED;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign read_unfinish = (state_q != S_IDLE);

    always_comb begin
        line_data = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            line_data[k*32 +: 32] = line_q[k];
        end
    end

    assign i_ret_data = line_data;
    assign d_ret_data = line_data;

    always_comb begin
        state_d     = state_q;
        req_d_d     = req_d_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        size_d      = size_q;
        ptr_d       = ptr_q;
        buf_we      = 1'b0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // D wins outright; a D request stalled on the write engine
                // still blocks I so ordering against writes is preserved.
                d_rd_rdy = d_rd_req & wr_idle;
                i_rd_rdy = i_rd_req & ~d_rd_req;
                if (d_rd_req && wr_idle) begin
                    req_d_d = 1'b1;
                    addr_d  = d_rd_addr;
                    burst_d = d_rd_burst;
                    size_d  = d_rd_size;
                    ptr_d   = '0;
                    state_d = S_AR;
                end else if (i_rd_req && !d_rd_req) begin
                    req_d_d = 1'b0;
                    addr_d  = i_rd_addr;
                    burst_d = 1'b1;
                    size_d  = 2'd2;
                    ptr_d   = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    buf_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (rlast || (ptr_q == last_ptr)) begin
                        state_d = S_RET;
                    end
                end
            end
            S_RET: begin
                i_ret_valid = ~req_d_q;
                d_ret_valid = req_d_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_d_q <= 1'b0;
            addr_q  <= 32'd0;
            burst_q <= 1'b0;
            size_q  <= 2'd0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_d_q <= req_d_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            size_q  <= size_d;
            ptr_q   <= ptr_d;
        end
    end

    // Line buffer deliberately has no reset; its contents are only meaningful
    // after a completed transaction.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_q[ptr_q] <= rdata;
        end
    end

endmodule
`default_nettype wire
